// File: rtl/dynvc_free_slot_manager.sv
// Shared-buffer slot allocator: FIFO free list, per-VC reserved minimum plus shared pool, illegal-op detection.
// Grant is combinational from state; all updates commit at the next edge; never stalls, illegal requests only raise an error pulse.
module dynvc_free_slot_manager #(
   parameter int memory_bank_depth = 32,
   parameter int num_vcs           = 4,
   parameter int num_reserved      = 2,
   localparam int addr_width       = $clog2(memory_bank_depth),
   localparam int cnt_width        = addr_width + 1,
   localparam int vc_width         = $clog2(num_vcs)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          alloc_req,
   input  logic [vc_width-1:0]           alloc_vc,
   output logic [addr_width-1:0]         alloc_slot,
   output logic [num_vcs-1:0]            alloc_ready,
   input  logic                          free_req,
   input  logic [vc_width-1:0]           free_vc,
   input  logic [addr_width-1:0]         free_slot,
   output logic [cnt_width-1:0]          free_count,
   output logic [num_vcs*cnt_width-1:0]  vc_occupancy,
   output logic                          memory_bank_full,
   output logic                          memory_bank_empty,
   output logic                          error_bad_alloc,
   output logic                          error_bad_free
);

   localparam int shared_pool = memory_bank_depth - num_vcs * num_reserved;
   localparam logic [cnt_width-1:0] res_c   = cnt_width'(num_reserved);
   localparam logic [cnt_width-1:0] pool_c  = cnt_width'(shared_pool);
   localparam logic [cnt_width-1:0] depth_c = cnt_width'(memory_bank_depth);

   if (num_vcs * num_reserved > memory_bank_depth) begin : g_bad_cfg
      $error("dynvc_free_slot_manager: num_vcs*num_reserved exceeds memory_bank_depth");
   end

   logic [addr_width-1:0] list_q [memory_bank_depth];
   logic [addr_width-1:0] list_d [memory_bank_depth];
   logic [addr_width-1:0] head_q, head_d, tail_q, tail_d;
   logic [cnt_width-1:0]  free_count_q, free_count_d;
   logic [cnt_width-1:0]  occ_q [num_vcs];
   logic [cnt_width-1:0]  occ_d [num_vcs];
   logic [memory_bank_depth-1:0] bitmap_q, bitmap_d;
   logic                  err_alloc_q, err_alloc_d, err_free_q, err_free_d;
   logic [cnt_width-1:0]  shared_used;
   logic                  alloc_ok, free_ok;

   // Shared usage is recomputed from occupancy so same-VC alloc+free nets out exactly.
   always_comb begin
      shared_used = '0;
      alloc_ready = '0;
      for (int v = 0; v < num_vcs; v++) begin
         if (occ_q[v] > res_c) shared_used = shared_used + (occ_q[v] - res_c);
      end
      for (int v = 0; v < num_vcs; v++) begin
         alloc_ready[v] = (free_count_q != '0) && ((occ_q[v] < res_c) || (shared_used < pool_c));
      end
   end

   always_comb begin
      alloc_ok     = alloc_req && alloc_ready[alloc_vc];
      free_ok      = free_req && bitmap_q[free_slot] && (occ_q[free_vc] != '0);
      list_d       = list_q;
      head_d       = head_q;
      tail_d       = tail_q;
      bitmap_d     = bitmap_q;
      occ_d        = occ_q;
      free_count_d = free_count_q;
      err_alloc_d  = alloc_req && !alloc_ok;
      err_free_d   = free_req && !free_ok;
      if (free_ok) begin
         list_d[tail_q]      = free_slot;
         tail_d              = tail_q + addr_width'(1);
         bitmap_d[free_slot] = 1'b0;
         occ_d[free_vc]      = occ_d[free_vc] - cnt_width'(1);
      end
      if (alloc_ok) begin
         head_d                 = head_q + addr_width'(1);
         bitmap_d[list_q[head_q]] = 1'b1;
         occ_d[alloc_vc]        = occ_d[alloc_vc] + cnt_width'(1);
      end
      if (alloc_ok && !free_ok)      free_count_d = free_count_q - cnt_width'(1);
      else if (free_ok && !alloc_ok) free_count_d = free_count_q + cnt_width'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < memory_bank_depth; i++) list_q[i] <= addr_width'(i);
         for (int v = 0; v < num_vcs; v++) occ_q[v] <= '0;
         head_q       <= '0;
         tail_q       <= '0;
         free_count_q <= depth_c;
         bitmap_q     <= '0;
         err_alloc_q  <= 1'b0;
         err_free_q   <= 1'b0;
      end else begin
         list_q       <= list_d;
         occ_q        <= occ_d;
         head_q       <= head_d;
         tail_q       <= tail_d;
         free_count_q <= free_count_d;
         bitmap_q     <= bitmap_d;
         err_alloc_q  <= err_alloc_d;
         err_free_q   <= err_free_d;
      end
   end

   always_comb begin
      vc_occupancy = '0;
      for (int v = 0; v < num_vcs; v++) begin
         vc_occupancy[(num_vcs-1-v)*cnt_width +: cnt_width] = occ_q[v];
      end
   end

   assign alloc_slot        = list_q[head_q];
   assign free_count        = free_count_q;
   assign memory_bank_full  = (free_count_q == '0);
   assign memory_bank_empty = (free_count_q == depth_c);
   assign error_bad_alloc   = err_alloc_q;
   assign error_bad_free    = err_free_q;

endmodule

// File: tb/tb_dynvc_free_slot_manager.sv
// Bench for dynvc_free_slot_manager: queue-based free-list model with a scoreboard of expected grants and error pulses.
module tb_dynvc_free_slot_manager;

   localparam int D = 32, NV = 4, R = 2, AW = 5, CW = 6, VW = 2;
   localparam int POOL = D - NV * R;

   logic              clk = 1'b0;
   logic              reset;
   logic              alloc_req;
   logic [VW-1:0]     alloc_vc;
   logic [AW-1:0]     alloc_slot;
   logic [NV-1:0]     alloc_ready;
   logic              free_req;
   logic [VW-1:0]     free_vc;
   logic [AW-1:0]     free_slot;
   logic [CW-1:0]     free_count;
   logic [NV*CW-1:0]  vc_occupancy;
   logic              memory_bank_full, memory_bank_empty;
   logic              error_bad_alloc, error_bad_free;

   dynvc_free_slot_manager #(.memory_bank_depth(D), .num_vcs(NV), .num_reserved(R)) dut (
      .clk(clk), .reset(reset),
      .alloc_req(alloc_req), .alloc_vc(alloc_vc), .alloc_slot(alloc_slot), .alloc_ready(alloc_ready),
      .free_req(free_req), .free_vc(free_vc), .free_slot(free_slot),
      .free_count(free_count), .vc_occupancy(vc_occupancy),
      .memory_bank_full(memory_bank_full), .memory_bank_empty(memory_bank_empty),
      .error_bad_alloc(error_bad_alloc), .error_bad_free(error_bad_free)
   );

   always #5 clk = ~clk;

   int checks = 0, passes = 0, fails = 0;
   int fl[$];
   int occ[NV];
   bit bm[D];
   int exp_slot_q[$];
   logic [1:0] exp_err_q[$];

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end else begin
         passes++;
      end
   endtask

   function automatic int model_su();
      int s = 0;
      for (int v = 0; v < NV; v++) if (occ[v] > R) s += occ[v] - R;
      return s;
   endfunction

   function automatic logic [NV-1:0] model_ready();
      logic [NV-1:0] r = '0;
      for (int v = 0; v < NV; v++) r[v] = (fl.size() != 0) && ((occ[v] < R) || (model_su() < POOL));
      return r;
   endfunction

   function automatic int dut_occ(input int v);
      return int'(vc_occupancy[(NV-1-v)*CW +: CW]);
   endfunction

   task automatic check_state();
      check_val("free_count", free_count, fl.size());
      check_val("full", memory_bank_full, fl.size() == 0);
      check_val("empty", memory_bank_empty, fl.size() == D);
      for (int v = 0; v < NV; v++) check_val($sformatf("occ%0d", v), dut_occ(v), occ[v]);
   endtask

   task automatic apply_reset();
      reset = 1'b1; alloc_req = 1'b0; free_req = 1'b0;
      alloc_vc = '0; free_vc = '0; free_slot = '0;
      @(posedge clk); #1;
      reset = 1'b0;
      fl.delete();
      for (int i = 0; i < D; i++) fl.push_back(i);
      for (int v = 0; v < NV; v++) occ[v] = 0;
      for (int i = 0; i < D; i++) bm[i] = 1'b0;
      exp_slot_q.delete();
      exp_err_q.delete();
      check_val("rst_free_count", free_count, 32);
      check_val("rst_empty", memory_bank_empty, 1);
      check_val("rst_full", memory_bank_full, 0);
      check_val("rst_alloc_slot", alloc_slot, 0);
      check_val("rst_occ", vc_occupancy, 0);
      check_val("rst_errs", {error_bad_alloc, error_bad_free}, 0);
   endtask

   // One clock: drive, check combinational grant before the edge, then registered results after it.
   task automatic cycle(input bit a_req, input int a_vc, input bit f_req, input int f_vc, input int f_slot);
      logic [NV-1:0] rdy;
      bit a_ok, f_ok;
      logic [1:0] e;
      int s;
      alloc_req = a_req; alloc_vc = VW'(a_vc);
      free_req = f_req; free_vc = VW'(f_vc); free_slot = AW'(f_slot);
      rdy  = model_ready();
      a_ok = a_req && rdy[a_vc];
      f_ok = f_req && bm[f_slot] && (occ[f_vc] != 0);
      if (a_ok) exp_slot_q.push_back(fl[0]);
      exp_err_q.push_back({a_req && !a_ok, f_req && !f_ok});
      @(negedge clk);
      check_val("alloc_ready", alloc_ready, rdy);
      if (a_ok) begin
         s = exp_slot_q.pop_front();
         check_val("alloc_slot", alloc_slot, s);
      end
      if (a_ok) begin
         s = fl.pop_front();
         bm[s] = 1'b1;
         occ[a_vc]++;
      end
      if (f_ok) begin
         fl.push_back(f_slot);
         bm[f_slot] = 1'b0;
         occ[f_vc]--;
      end
      @(posedge clk); #1;
      alloc_req = 1'b0; free_req = 1'b0;
      e = exp_err_q.pop_front();
      check_val("error_bad_alloc", error_bad_alloc, e[1]);
      check_val("error_bad_free", error_bad_free, e[0]);
      check_state();
   endtask

   initial begin
      apply_reset();

      // Reserved then shared allocation on VC0 until the shared pool is exhausted.
      for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0, 0);
      check_val("occ0_after4", dut_occ(0), 4);
      check_val("fc_after4", free_count, 28);
      for (int i = 0; i < 22; i++) cycle(1, 0, 0, 0, 0);
      check_val("ready_pool_exhausted", alloc_ready, 4'b1110);
      for (int v = 1; v < NV; v++) begin
         cycle(1, v, 0, 0, 0);
         cycle(1, v, 0, 0, 0);
      end
      check_val("bank_full", memory_bank_full, 1);
      for (int v = 0; v < NV; v++) cycle(1, v, 0, 0, 0);
      check_val("full_err_alloc", error_bad_alloc, 1);
      cycle(1, 1, 1, 0, 3);
      check_val("full_alloc_with_free", free_count, 1);

      // Head/tail wrap: slot 5 resurfaces only after 6..31 are handed out.
      apply_reset();
      for (int i = 0; i < 6; i++) cycle(1, i % NV, 0, 0, 0);
      cycle(0, 0, 1, 1, 5);
      for (int i = 0; i < 26; i++) cycle(1, i % NV, 0, 0, 0);
      check_val("wrap_head_slot5", alloc_slot, 5);
      cycle(1, 2, 0, 0, 0);

      // Illegal frees.
      apply_reset();
      for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0);
      cycle(0, 0, 1, 0, 9);
      check_val("bad_free_unalloc", error_bad_free, 1);
      cycle(0, 0, 1, 2, 1);
      check_val("bad_free_occ0", error_bad_free, 1);
      check_val("bad_free_fc", free_count, 29);
      cycle(0, 0, 0, 0, 0);
      check_val("bad_free_pulse_end", error_bad_free, 0);

      // Simultaneous alloc and free on the same VC.
      apply_reset();
      cycle(1, 1, 0, 0, 0);
      cycle(1, 1, 0, 0, 0);
      cycle(1, 1, 1, 1, 0);
      check_val("same_vc_occ1", dut_occ(1), 2);
      check_val("same_vc_fc", free_count, 30);
      cycle(0, 0, 1, 1, 0);
      check_val("slot0_cleared", error_bad_free, 1);
      cycle(1, 0, 1, 0, 3);
      check_val("free_eq_alloc_slot", error_bad_free, 1);

      // Random traffic against the model.
      apply_reset();
      for (int i = 0; i < 400; i++) begin
         cycle($urandom_range(0, 99) < 60, $urandom_range(0, NV-1),
               $urandom_range(0, 99) < 45, $urandom_range(0, NV-1), $urandom_range(0, D-1));
      end

      // Reset in the middle of traffic.
      for (int i = 0; i < 5; i++) cycle(1, i % NV, 0, 0, 0);
      check_val("pre_reset_occ_nonzero", vc_occupancy != 0, 1);
      apply_reset();
      cycle(1, 3, 0, 0, 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
